serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset, sampled on rising clk.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: first operand, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: second operand, captured when start is accepted.
REQ-007 The block SHALL have port carry_in, input, 1 bit: initial carry, captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result, (a+b+carry_in) mod 2^WIDTH.
REQ-011 The block SHALL have port carry_out, output, 1 bit: registered carry out of bit WIDTH-1.

Function
REQ-012 The block SHALL compute the sum bit-serially, LSB first, one bit per clock, using a single 1-bit full-adder slice built from two half adders (sum = x^y^c, carry = x&y | (x^y)&c).
REQ-013 The FSM SHALL have exactly three states, IDLE, RUN and DONE.
REQ-014 IDLE -> RUN SHALL occur on a rising edge with start=1; on that edge, a, b and carry_in SHALL be captured into internal shift and carry registers and the bit counter SHALL be cleared to 0.
REQ-015 In RUN, each rising edge SHALL add the current LSBs of the operand shift registers with the carry register, shift the result bit into the result shift register, update the carry register, shift both operand registers right by one, and increment the counter.
REQ-016 RUN -> DONE SHALL occur on the edge that processes bit WIDTH-1 (counter = WIDTH-1); on that same edge, sum and carry_out SHALL be loaded with the complete result.
REQ-017 DONE -> IDLE SHALL occur unconditionally on the next rising edge.
REQ-018 Latency: with start sampled at edge E0, done SHALL be high in the cycle after edge E0+WIDTH and low again after edge E0+WIDTH+1; the total occupancy is WIDTH+1 cycles.
REQ-019 start SHALL be ignored in RUN and DONE; there SHALL be no queuing, so the earliest subsequent accepted start is at the first edge in IDLE.
REQ-020 Changes on a, b or carry_in after acceptance SHALL NOT affect the running operation.
REQ-021 sum and carry_out SHALL change only on the RUN -> DONE edge and on reset, and SHALL hold their values through IDLE and the next operation until its completion.
REQ-022 Overflow SHALL wrap: bits above WIDTH-1 are discarded from sum and reported only through carry_out.

Reset
REQ-023 With rst=1 at a rising edge, the FSM SHALL go to IDLE and the counter, operand, carry and result registers SHALL clear to 0, giving busy=0, done=0, sum=0 and carry_out=0.
REQ-024 rst SHALL take priority over start and over any in-progress operation; an operation interrupted by reset SHALL be aborted without done or any result update.
REQ-025 After rst deasserts, a start on the first rising edge SHALL be accepted normally.

Verification (WIDTH=8)
REQ-026 Stimulus: a=0x00, b=0x00, carry_in=0, start for 1 cycle. Required response: busy=1 for 9 cycles, a single done pulse 8 edges after acceptance, sum=0x00, carry_out=0.
REQ-027 Stimulus: a=0xFF, b=0x01, carry_in=0. Required response: sum=0x00, carry_out=1 (wrap-around).
REQ-028 Stimulus: a=0xA5, b=0x5A, carry_in=1. Required response: sum=0x00, carry_out=1; then a=0x12, b=0x34, carry_in=0 gives sum=0x46, carry_out=0, and the previous result holds until the new done.
REQ-029 Stimulus: hold start=1 continuously, change a and b mid-RUN. Required response: the result uses the captured operands, and the next operation is accepted only on the edge after DONE (i.e. every 10 cycles).
REQ-030 Stimulus: assert rst for 1 cycle at RUN bit 3. Required response: the next cycle shows busy=0, sum=0, carry_out=0, no done pulse, and a following start completes correctly.
REQ-031 Stimulus: exhaustive or random comparison against a+b+carry_in over at least 1000 operations. Required response: zero mismatches.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: captures two WIDTH-bit operands and a carry on start, then
// adds one bit per clock (LSB first) through a single full-adder slice.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   res_r;
  logic [WIDTH-1:0]   sum_r;
  logic               carry_r;
  logic               carry_out_r;
  logic               busy_r;
  logic               done_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         fa_s;
  logic               last_bit_s;

  // One-bit full adder made of two half adders; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    logic hs1, hc1, hs2, hc2;
    hs1 = x ^ y;
    hc1 = x & y;
    hs2 = hs1 ^ c;
    hc2 = hs1 & c;
    return {hc1 | hc2, hs2};
  endfunction

  // Adder slice inputs and final-bit detection.
  always_comb begin
    fa_s       = full_add(a_r[0], b_r[0], carry_r);
    last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (last_bit_s) state_next_s = DONE;
        else            state_next_s = RUN;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register plus registered status flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Operand capture, serial shift datapath and result load on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= '0;
      b_r         <= '0;
      res_r       <= '0;
      carry_r     <= 1'b0;
      cnt_r       <= '0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= carry_in;
            cnt_r   <= '0;
          end
        end
        RUN: begin
          // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          a_r     <= a_r >> 1;
          b_r     <= b_r >> 1;
          res_r   <= {fa_s[0], res_r[WIDTH-1:1]};
          carry_r <= fa_s[1];
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_bit_s) begin
            sum_r       <= {fa_s[0], res_r[WIDTH-1:1]};
            carry_out_r <= fa_s[1];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign sum       = sum_r;
  assign carry_out = carry_out_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): directed vector table,
// multi-cycle corner sequences and random operations against a+b+carry_in.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  int checks = 0;
  int errors = 0;
  logic [8:0] last_res = 9'd0;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vc;
    logic [7:0] es;
    logic       eco;
  } vec_t;

  vec_t tbl[7];

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .carry_in(carry_in),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one operation starting at the current negedge; returns {carry_out,sum}.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        output logic [8:0] res);
    int k;
    int bc;
    logic [8:0] held;
    a = ta; b = tb; carry_in = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); carry_in = 1'($urandom);
    k = 0; bc = 0; held = 9'h1ff;
    while (!done && k < 20) begin
      if (busy) bc++;
      if (k == WIDTH - 1) held = {carry_out, sum};
      @(negedge clk);
      k++;
    end
    if (busy) bc++;
    chk("done_latency", 32'(k), 32'(WIDTH));
    chk("busy_cycles", 32'(bc), 32'(WIDTH + 1));
    chk("result_hold", 32'(held), 32'(last_res));
    res = {carry_out, sum};
    last_res = res;
    @(negedge clk);
    chk("done_pulse_end", 32'({done, busy}), 32'(0));
  endtask

  initial begin : main
    logic [8:0] res;
    logic [8:0] exp;
    logic [7:0] x1, y1, x2, y2;
    int dn_t[$];
    logic [8:0] dn_v[$];

    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    tbl[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'({busy, done, carry_out, sum}), 32'(0));

    // Start on the very first edge after reset release.
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].va, tbl[i].vb, tbl[i].vc, res);
      chk($sformatf("vec%0d_sum", i), 32'(res[7:0]), 32'(tbl[i].es));
      chk($sformatf("vec%0d_cout", i), 32'(res[8]), 32'(tbl[i].eco));
    end

    // start held high with operands changed mid-run: one accept every WIDTH+2 cycles.
    x1 = 8'h3C; y1 = 8'hD9; x2 = 8'h21; y2 = 8'h47;
    a = x1; b = y1; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      if (k == 3) begin a = x2; b = y2; end
      if (done) begin dn_t.push_back(k); dn_v.push_back({carry_out, sum}); end
      if (k < 29) @(negedge clk);
    end
    start = 1'b0;
    chk("hold_start_ndone", 32'(dn_t.size()), 32'(3));
    if (dn_t.size() >= 2) begin
      chk("hold_start_first", 32'(dn_t[0]), 32'(WIDTH));
      chk("hold_start_period", 32'(dn_t[1] - dn_t[0]), 32'(WIDTH + 2));
      chk("hold_start_res0", 32'(dn_v[0]), 32'({1'b0, x1} + {1'b0, y1}));
      chk("hold_start_res1", 32'(dn_v[1]), 32'({1'b0, x2} + {1'b0, y2}));
    end
    last_res = 9'({1'b0, x2} + {1'b0, y2});
    repeat (2) @(negedge clk);
    chk("hold_start_idle", 32'(busy), 32'(0));

    // Reset in the middle of an operation aborts it silently.
    a = 8'hF0; b = 8'h0F; carry_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", 32'({busy, done, carry_out, sum}), 32'(0));
    res = 9'd0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) res = 9'h1ff;
    end
    chk("abort_quiet", 32'(res), 32'(0));
    last_res = 9'd0;
    run_op(8'h9B, 8'h64, 1'b1, res);
    chk("after_abort", 32'(res), 32'(9'h100));

    // Random operations against plain arithmetic.
    for (int i = 0; i < 1000; i++) begin
      x1 = 8'($urandom); y1 = 8'($urandom);
      exp = 9'({1'b0, x1} + {1'b0, y1} + 9'(i % 2));
      run_op(x1, y1, 1'(i % 2), res);
      chk("random_op", 32'(res), 32'(exp));
      if ((i % 7) == 0) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
